// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop synchroniser, half-bit start validation,
// mid-bit sampling, one-cycle data_valid / frame_err strobes.
module uart_rx #(
    parameter int CLK_PER_BIT = 1250,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLK_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed;

    // Synchroniser presets to the idle-line level so reset never fakes a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            armed      <= 1'b1;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            // A start is only accepted after the line has been seen high while
            // enabled, so re-enabling mid-frame cannot lock onto a data bit.
            armed      <= enable & (armed | rx_s);

            if (!enable) begin
                state   <= S_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (armed && !rx_s) begin
                            state <= S_START;
                            cnt   <= '0;
                        end
                    end

                    S_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_idx == IDX_LAST) begin
                                state   <= S_STOP;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state      <= S_IDLE;
                                data_out   <= shreg;
                                data_valid <= 1'b1;
                            end else begin
                                state     <= S_WAIT_HIGH;
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    // A held-low line (break) must rise before another frame is considered.
                    S_WAIT_HIGH: begin
                        if (rx_s) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_PER_BIT=16, DATA_BITS=8 with a byte scoreboard.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          rx;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    uart_rx #(.CLK_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DB-1:0] exp_q[$];
    int   n_valid        = 0;
    int   n_ferr         = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;
    logic prev_dv        = 1'b0;
    logic prev_fe        = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every data_valid strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                check("dv_single_cycle", prev_dv, 1'b0);
                check("dv_fe_exclusive", frame_err, 1'b0);
                check("dv_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    check("data_out", data_out, exp_q.pop_front());
                n_valid++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            if (frame_err) begin
                check("fe_single_cycle", prev_fe, 1'b0);
                n_ferr++;
            end
        end
        prev_dv = data_valid;
        prev_fe = frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop_bit;
        wait_cyc(CPB);
    endtask

    initial begin
        int t0;
        int lat;
        logic [DB-1:0] f0 = 8'hF0;
        logic [DB-1:0] f55 = 8'h55;

        rst    = 1'b1;
        enable = 1'b1;
        rx     = 1'b1;
        #12;
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(5);

        // Single frame 0xA5 with latency measurement.
        t0 = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        lat = last_valid_cyc - t0;
        check("a5_valid_count", n_valid, 1);
        check("a5_latency_window", (lat >= 154 && lat <= 156), 1'b1);
        check("a5_no_frame_err", n_ferr, 0);
        check("a5_busy_after", busy, 1'b0);
        check("a5_data_out", data_out, 8'hA5);
        wait_cyc(10);

        // Back-to-back 0x00 / 0xFF with a single stop bit.
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        check("b2b_valid_count", n_valid, 3);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);
        check("b2b_data_out", data_out, 8'hFF);
        wait_cyc(10);

        // Short glitch aborts at the half-bit sample.
        rx = 1'b0;
        wait_cyc(5);
        check("glitch_busy_during", busy, 1'b1);
        rx = 1'b1;
        wait_cyc(40);
        check("glitch_busy_after", busy, 1'b0);
        check("glitch_valid_count", n_valid, 3);
        check("glitch_ferr_count", n_ferr, 0);

        // Framing error followed by a held-low break, then a good frame.
        send_frame(8'h3C, 1'b0);
        wait_cyc(40);
        check("ferr_count", n_ferr, 1);
        check("ferr_valid_count", n_valid, 3);
        check("ferr_data_hold", data_out, 8'hFF);
        check("ferr_busy_in_break", busy, 1'b1);
        rx = 1'b1;
        wait_cyc(4);
        check("ferr_busy_after_rise", busy, 1'b0);
        wait_cyc(10);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        check("post_ferr_valid_count", n_valid, 4);
        check("post_ferr_data_out", data_out, 8'h42);
        wait_cyc(10);

        // Enable dropped and restored inside data bit 3 of 0xF0 (line still low).
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = f0[i];
            wait_cyc(CPB);
        end
        rx = f0[3];
        wait_cyc(8);
        enable = 1'b0;
        wait_cyc(2);
        check("en_drop_busy", busy, 1'b0);
        enable = 1'b1;
        wait_cyc(6);
        check("en_restore_no_restart", busy, 1'b0);
        for (int i = 4; i < DB; i++) begin
            rx = f0[i];
            wait_cyc(CPB);
        end
        rx = 1'b1;
        wait_cyc(CPB + 20);
        check("en_valid_count", n_valid, 4);
        check("en_ferr_count", n_ferr, 1);
        check("en_data_hold", data_out, 8'h42);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("en_next_valid_count", n_valid, 5);
        check("en_next_data_out", data_out, 8'h81);
        wait_cyc(10);

        // Reset asserted in the middle of a 0x55 frame.
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = f55[i];
            wait_cyc(CPB);
        end
        rx = f55[3];
        wait_cyc(8);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_data_out", data_out, 8'h00);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_data_valid", data_valid, 1'b0);
        check("rst_async_frame_err", frame_err, 1'b0);
        rx = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        check("rst_next_valid_count", n_valid, 6);
        check("rst_next_data_out", data_out, 8'h7E);

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++)
            wait_cyc(1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("total_ferr", n_ferr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It recovers bytes from the asynchronous serial line using the same CLK_PER_BIT timing convention as the transmit-side baud clock generator.
- Synchronises the incoming line, detects and validates the start bit, and samples each bit at mid-period.
- Delivers each byte with a one-cycle valid strobe, or flags a framing error.
- Sits between the board RX pin and the sensor command/packet parser.

Parameters:
- CLK_PER_BIT, 1250: system clock cycles per serial bit. Legal range is ≥ 4. HALF_BIT = CLK_PER_BIT/2, integer division.
- DATA_BITS, 8: data bits per frame, sent LSB first. Legal range 5..8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  receiver enable. Low forces IDLE and clears all counters.
- rx  in  1  serial line, idle high, asynchronous to clk
- data_out  out  DATA_BITS  last correctly framed byte. Holds its value until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out is updated
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; counters = 0; shift register = 0.
  - data_out = 0, data_valid = 0, frame_err = 0, busy = 0.
  - Synchroniser flops preset to 1 (idle line).
- Input synchronisation:
  - Two-flop synchroniser gives rx_s, which lags rx by 2 cycles.
  - All decisions use rx_s only.
- Bit counter:
  - Width ceil(log2(CLK_PER_BIT)).
  - Cleared on every state entry; increments every cycle while in START, DATA or STOP.
- States:
  - IDLE:
    - data_valid and frame_err are 0 except for their single pulse cycle.
    - If enable=1 and rx_s=0, go to START with cnt=0.
  - START:
    - When cnt == HALF_BIT-1, sample rx_s.
    - rx_s = 0: go to DATA with cnt=0, bit_idx=0.
    - rx_s = 1: treat as a glitch and return to IDLE with no output.
  - DATA:
    - When cnt == CLK_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift, so LSB-first arrival), set cnt=0 and increment bit_idx.
    - After bit_idx reaches DATA_BITS-1 and that bit is sampled, go to STOP.
  - STOP:
    - When cnt == CLK_PER_BIT-1, sample rx_s.
    - rx_s = 1: on that edge data_out ← shift register and data_valid ← 1; go to IDLE.
    - rx_s = 0: frame_err ← 1 and data_out is unchanged; go to WAIT_HIGH.
  - WAIT_HIGH:
    - Remain here until rx_s = 1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Pulses: data_valid and frame_err are registered, high for exactly one clk cycle, and never both high at once.
- Latency: data_valid rises 2 (synchroniser) + HALF_BIT + DATA_BITS·CLK_PER_BIT + CLK_PER_BIT + 1 cycles after the start-bit falling edge on rx, to within ±1 cycle.
- Back-to-back frames: a start edge seen in IDLE on the cycle after STOP is accepted. A stop bit of one full period is sufficient.
- enable deasserted in any state:
  - On the next edge go to IDLE and clear counters and bit_idx.
  - No pulse is generated; data_out holds.
- enable reasserted: reception starts only on a fresh rx_s=0 while in IDLE.
- rst asserted mid-frame: immediate return to reset values. The partial byte is discarded.
- rx changes other than at sample points are ignored; there is no majority voting.

Test Plan (CLK_PER_BIT=16, DATA_BITS=8, enable=1 unless stated):
- Send 0xA5 framed 8N1 → one data_valid pulse, data_out=0xA5, frame_err never high, busy low after the pulse.
- Send 0x00 then 0xFF back-to-back with one stop bit between → two data_valid pulses exactly 160 cycles apart, with data_out 0x00 then 0xFF.
- Drive rx low for 5 cycles then high → START aborts at the half-bit sample, no data_valid or frame_err, busy returns to 0.
- Send 0x3C with the stop bit low, holding rx low for 40 more cycles → one frame_err pulse, data_out keeps its previous value, state stays in WAIT_HIGH until rx rises, then the next 0x42 frame is received correctly.
- Drop enable during data bit 3 of a frame, then restore it → no pulses and data_out unchanged. The remainder of that frame must not produce a valid byte. The following clean 0x81 frame is received.
- Assert rst for 2 cycles in the middle of a 0x55 frame → all outputs 0 immediately (asynchronously). After release, a clean 0x7E frame yields data_out=0x7E.
